// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive monitor: segment patterns and FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

  // Segment patterns, bit0=a .. bit6=g, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Indexed by hex value: SEG_TABLE[i] is the pattern for digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } mon_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Decodes a 7-segment pattern back to its hex digit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports: pattern (7b segment pattern) -> hit (pattern is a hex digit), value (4b digit, 0 on miss).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] value
);

  always_comb begin
    hit   = 1'b0;
    value = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        hit   = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Receive-side 7-seg monitor: deglitch segment bus, decode to hex digit, check count-up order.
// Latency: pattern sampled into seg_q at edge k and held -> outputs updated after edge k+STABLE_CYCLES.
// Backpressure: none; free-running sampler, one accept per stable run.
// Ports: clk, rst_n (sync, active-low), segments[6:0], clr_err -> digit[3:0], digit_valid,
//        blank, bad_pat, seq_err, locked, err_count[ERR_W-1:0].
// Build option: define SEG7_SEQ_CHECK_EN to include the count-up sequence checker.
module seg7_decode_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       segments,
  input  logic             clr_err,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             bad_pat,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  // cnt_q counts edges seg_q stayed unchanged after being loaded, so a run of
  // STABLE_CYCLES identical samples is complete when cnt_q reaches STABLE_CYCLES-1.
  localparam logic [3:0]       ACCEPT_CNT = 4'(STABLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  logic [6:0]       seg_q, seg_d;
  logic [3:0]       cnt_q, cnt_d;
  mon_state_e       state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic             blank_q, blank_d;
  logic             bad_pat_q, bad_pat_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             seg_chg;
  logic             accept;
  logic             dec_hit;
  logic [3:0]       dec_value;
  logic             err_inc;

`ifdef SEG7_SEQ_CHECK_EN
  logic             seq_err_q, seq_err_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       prev_inc;
`endif

  seg7_pattern_decode u_decode (
    .pattern (seg_q),
    .hit     (dec_hit),
    .value   (dec_value)
  );

  always_comb begin
    seg_d   = segments;
    seg_chg = (segments != seg_q);
    accept  = (state_q == SETTLE) && (cnt_q == ACCEPT_CNT);

    // Counter saturates at the accept threshold; LOCKED blocks a second accept.
    if (seg_chg)                 cnt_d = 4'd0;
    else if (cnt_q < ACCEPT_CNT) cnt_d = cnt_q + 4'd1;
    else                         cnt_d = cnt_q;

    if (seg_chg)     state_d = SETTLE;
    else if (accept) state_d = LOCKED;
    else             state_d = state_q;

    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    blank_d       = blank_q;
    bad_pat_d     = 1'b0;

    if (accept) begin
      if (dec_hit) begin
        digit_d       = dec_value;
        digit_valid_d = 1'b1;
        blank_d       = 1'b0;
      end else if (seg_q == SEG_BLANK) begin
        blank_d = 1'b1;
      end else begin
        bad_pat_d = 1'b1;
      end
    end

`ifdef SEG7_SEQ_CHECK_EN
    prev_inc    = prev_q + 4'd1;
    seq_err_d   = 1'b0;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    if (accept && dec_hit) begin
      // Same digit again is a re-accept after a glitch, not an error.
      if (have_prev_q && (dec_value != prev_inc) && (dec_value != prev_q))
        seq_err_d = 1'b1;
      prev_d      = dec_value;
      have_prev_d = 1'b1;
    end else if (accept && (seg_q == SEG_BLANK)) begin
      have_prev_d = 1'b0;
    end
    err_inc = bad_pat_d | seq_err_d;
`else
    err_inc = bad_pat_d;
`endif

    // A clear coinciding with a new error keeps that error.
    if (clr_err)                          err_count_d = {{(ERR_W-1){1'b0}}, err_inc};
    else if (err_inc && (err_count_q != ERR_MAX)) err_count_d = err_count_q + 1'b1;
    else                                  err_count_d = err_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q         <= 7'h00;
      cnt_q         <= 4'd0;
      state_q       <= SETTLE;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b0;
      bad_pat_q     <= 1'b0;
      err_count_q   <= '0;
`ifdef SEG7_SEQ_CHECK_EN
      seq_err_q     <= 1'b0;
      have_prev_q   <= 1'b0;
      prev_q        <= 4'd0;
`endif
    end else begin
      seg_q         <= seg_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      blank_q       <= blank_d;
      bad_pat_q     <= bad_pat_d;
      err_count_q   <= err_count_d;
`ifdef SEG7_SEQ_CHECK_EN
      seq_err_q     <= seq_err_d;
      have_prev_q   <= have_prev_d;
      prev_q        <= prev_d;
`endif
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign blank       = blank_q;
  assign bad_pat     = bad_pat_q;
  assign locked      = (state_q == LOCKED);
  assign err_count   = err_count_q;
`ifdef SEG7_SEQ_CHECK_EN
  assign seq_err     = seq_err_q;
`else
  assign seq_err     = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Bench for seg7_decode_monitor: directed scenarios then randomized runs vs a run-length model.
// Latency: checks every output 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seg7_decode_monitor;

  localparam int S     = 4;
  localparam int ERR_W = 4;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       segments;
  logic             clr_err;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             blank;
  logic             bad_pat;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  always #5 clk = ~clk;

  seg7_decode_monitor #(.STABLE_CYCLES(S), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segments    (segments),
    .clr_err     (clr_err),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .bad_pat     (bad_pat),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  // Independent copy of the display encoding, digit order 0..F.
  logic [6:0] ref_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: a run of identical samples is accepted once, when it reaches S.
  logic [6:0] run_val;
  int         run_len;
  int         m_digit, m_err, m_prev;
  bit         m_dv, m_blank, m_bad, m_seq, m_locked, m_have_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (ref_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [6:0] s, input bit clr, input bit rn);
    int  v;
    bit  acc, same;
    if (!rn) begin
      run_val = 7'h00; run_len = 1;
      m_digit = 0; m_err = 0; m_prev = 0;
      m_dv = 0; m_blank = 0; m_bad = 0; m_seq = 0; m_locked = 0; m_have_prev = 0;
      return;
    end
    acc  = (run_len == S);
    same = (s == run_val);
    m_dv = 0; m_bad = 0; m_seq = 0;
    if (acc) begin
      v = lookup(run_val);
      if (v >= 0) begin
        m_digit = v; m_dv = 1; m_blank = 0;
`ifdef SEG7_SEQ_CHECK_EN
        if (m_have_prev && v != ((m_prev + 1) % 16) && v != m_prev) m_seq = 1;
`endif
        m_prev = v; m_have_prev = 1;
      end else if (run_val == 7'h00) begin
        m_blank = 1; m_have_prev = 0;
      end else begin
        m_bad = 1;
      end
    end
    if (clr)                        m_err = (m_bad || m_seq) ? 1 : 0;
    else if ((m_bad || m_seq) && m_err < EMAX) m_err++;
    m_locked = (acc || m_locked) && same;
    if (same) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_val = s; run_len = 1;
    end
  endtask

  task automatic step(input logic [6:0] s, input bit clr, input bit rn);
    segments = s;
    clr_err  = clr;
    rst_n    = rn;
    @(posedge clk);
    model_edge(s, clr, rn);
    #1;
    chk("digit",       32'(digit),       32'(m_digit));
    chk("digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("blank",       32'(blank),       32'(m_blank));
    chk("bad_pat",     32'(bad_pat),     32'(m_bad));
    chk("seq_err",     32'(seq_err),     32'(m_seq));
    chk("locked",      32'(locked),      32'(m_locked));
    chk("err_count",   32'(err_count),   32'(m_err));
  endtask

  task automatic hold(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0, 1'b1);
  endtask

  initial begin
    int         kind, len, nxt;
    logic [6:0] p;

    rst_n = 1'b0; segments = 7'h7F; clr_err = 1'b0;
    run_val = 7'h00; run_len = 1;

    // Reset with a live pattern on the bus.
    step(7'h7F, 1'b0, 1'b0);
    step(7'h7F, 1'b0, 1'b0);

    // Counting, wrap, and a skipped digit.
    hold(7'h3F, 8); hold(7'h06, 8);
    hold(7'h71, 8); hold(7'h3F, 8); hold(7'h5B, 8);
    // Short blank glitch, then a real blank and restart of the sequence.
    hold(7'h4F, 8); hold(7'h00, 2); hold(7'h4F, 8);
    hold(7'h00, 5); hold(7'h66, 8);
    // Invalid pattern, short and long holds.
    hold(7'h55, 6); hold(7'h6D, 6); hold(7'h55, 20);
    // Drive the error counter into saturation.
    for (int i = 0; i < 10; i++) begin
      hold(7'h55, 5); hold(7'h56, 5);
    end
    // Clear coinciding with an error: fifth sample of a new run is the accept edge.
    hold(7'h55, 4); step(7'h55, 1'b1, 1'b1); hold(7'h55, 3);
    // Clear alone.
    step(7'h55, 1'b1, 1'b1);
    // Reset mid-settle discards the partial pattern.
    hold(7'h7D, 2); step(7'h7D, 1'b0, 1'b0); hold(7'h7D, 6);

    // Randomized runs, biased toward counting up.
    for (int r = 0; r < 500; r++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 55)      p = ref_tab[(m_prev + 1) % 16];
      else if (kind < 70) p = ref_tab[$urandom_range(0, 15)];
      else if (kind < 80) p = 7'h00;
      else if (kind < 90) begin
        p = 7'(lookup(7'h00));
        do p = 7'($urandom_range(1, 127)); while (lookup(p) >= 0);
      end else            p = ref_tab[m_prev];
      len = int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) begin
        nxt = int'($urandom_range(0, 199));
        if (nxt == 0)      step(p, 1'b0, 1'b0);
        else if (nxt < 10) step(p, 1'b1, 1'b1);
        else               step(p, 1'b0, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
